// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: measured period, high time, duty word,
// an update strobe and the stuck-line level.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic [9:0]       duty;
  logic             valid;
  logic             stuck;

  modport master (output period, high, duty, valid, stuck);
  modport slave  (input  period, high, duty, valid, stuck);
endinterface

// File: rtl/pwm_capture.sv
// PWM measurement: synchronizes pwm_in, times period and high phase between rises,
// and divides high by period into a 10-bit duty word; flags a line with no rises.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 50_000,
  parameter int MIN_PERIOD = 16
) (
  input  logic              c100MHz,
  input  logic              rst,
  input  logic              pwm_in,
  pwm_capture_if.master     res
);

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {ARM, RUN, DIV} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] p_cap_q, p_cap_d;
  logic [CNT_W-1:0] h_cap_q, h_cap_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [9:0]       quo_q, quo_d;
  logic [3:0]       iter_q, iter_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [9:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_diff;
  logic             q_bit;
  logic             timeout_hit;
  logic             accept;

  always_comb begin
    sync1_d  = pwm_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    // Rise and fall are both registered so they share one latency.
    rise_d   = sync2_q & ~prev_q;
    fall_d   = ~sync2_q & prev_q;

    if (rise_q)
      cnt_d = CNT_W'(1);
    else if (cnt_q != TIMEOUT_C)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;

    hi_lat_d = fall_q ? cnt_q : hi_lat_q;

    rem_sh      = {rem_q, 1'b0};
    rem_diff    = rem_sh - {1'b0, p_cap_q};
    q_bit       = (rem_sh >= {1'b0, p_cap_q});
    // Fires on the single cycle cnt steps onto TIMEOUT; saturation cannot retrigger it.
    timeout_hit = !rise_q && (cnt_q == TIMEOUT_M1);
    accept      = rise_q && (cnt_q >= MIN_C);

    state_d  = state_q;
    p_cap_d  = p_cap_q;
    h_cap_d  = h_cap_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    iter_d   = iter_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;

    case (state_q)
      ARM: begin
        if (rise_q) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          p_cap_d = cnt_q;
          h_cap_d = hi_lat_q;
          rem_d   = hi_lat_q;
          quo_d   = '0;
          iter_d  = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d  = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quo_d  = {quo_q[8:0], q_bit};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          period_d = p_cap_q;
          high_d   = h_cap_q;
          duty_d   = {quo_q[8:0], q_bit};
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
          state_d  = RUN;
        end
      end
      default: state_d = ARM;
    endcase

    if (timeout_hit) begin
      period_d = '0;
      high_d   = '0;
      duty_d   = sync2_q ? 10'd1023 : 10'd0;
      valid_d  = 1'b1;
      stuck_d  = 1'b1;
      state_d  = ARM;
    end
  end

  always_ff @(posedge c100MHz or negedge rst) begin
    if (!rst) begin
      state_q  <= ARM;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      p_cap_q  <= '0;
      h_cap_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      iter_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      p_cap_q  <= p_cap_d;
      h_cap_q  <= h_cap_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      iter_q   <= iter_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign res.period = period_q;
  assign res.high   = high_q;
  assign res.duty   = duty_q;
  assign res.valid  = valid_q;
  assign res.stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM segments push hand-computed
// results; a monitor pops and compares on every valid pulse.
module tb_pwm_capture;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 10500;
  localparam int MIN_PERIOD = 16;

  logic c100MHz = 1'b0;
  logic rst     = 1'b0;
  logic pwm_in  = 1'b0;

  pwm_capture_if #(.CNT_W(CNT_W)) res_if ();

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .c100MHz (c100MHz),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .res     (res_if)
  );

  always #5 c100MHz = ~c100MHz;

  int unsigned cyc = 0;
  always @(posedge c100MHz) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned per;
    int unsigned hi;
    int unsigned duty;
    int unsigned stuck;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_errors = 0;

  bit          armed   = 1'b0;
  bit          pend_ok = 1'b0;
  int unsigned pend_per, pend_hi, pend_duty;
  int unsigned last_rise = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected result.
  always @(negedge c100MHz) begin
    if (rst && res_if.valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("valid_cycle", cyc, mon_e.cyc);
        checkOutput("period", res_if.period, mon_e.per);
        checkOutput("high", res_if.high, mon_e.hi);
        checkOutput("duty", res_if.duty, mon_e.duty);
        checkOutput("stuck", res_if.stuck, mon_e.stuck);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c100MHz);
      #1;
    end
  endtask

  // A rise closes the previous period: result visible 14 cycles after the pin change.
  task automatic drivePwm(input logic level);
    if (level && !pwm_in) begin
      if (armed && pend_ok)
        sb.push_back('{cyc + 14, pend_per, pend_hi, pend_duty, 0});
      armed     = 1'b1;
      pend_ok   = 1'b0;
      last_rise = cyc;
    end
    pwm_in = level;
  endtask

  task automatic applyStimulus(input int per, input int hi, input int n, input int duty);
    for (int i = 0; i < n; i++) begin
      drivePwm(1'b1);
      tick(hi);
      drivePwm(1'b0);
      tick(per - hi);
      pend_per  = per;
      pend_hi   = hi;
      pend_duty = duty;
      pend_ok   = (per >= MIN_PERIOD);
    end
  endtask

  task automatic holdHigh();
    drivePwm(1'b1);
    sb.push_back('{last_rise + 3 + TIMEOUT, 0, 0, 1023, 1});
    armed   = 1'b0;
    pend_ok = 1'b0;
    while (cyc < last_rise + TIMEOUT + 20) tick(1);
  endtask

  task automatic holdLow();
    sb.push_back('{last_rise + 3 + TIMEOUT, 0, 0, 0, 1});
    armed   = 1'b0;
    pend_ok = 1'b0;
    while (cyc < last_rise + TIMEOUT + 20) tick(1);
  endtask

  // Reset lands 5 cycles after the capture edge, while the divide is in flight.
  task automatic resetMidDivide();
    drivePwm(1'b1);
    tick(9);
    #2;
    rst    = 1'b0;
    pwm_in = 1'b0;
    #1;
    checkOutput("rst_period", res_if.period, 0);
    checkOutput("rst_high", res_if.high, 0);
    checkOutput("rst_duty", res_if.duty, 0);
    checkOutput("rst_valid", res_if.valid, 0);
    checkOutput("rst_stuck", res_if.stuck, 0);
    sb.delete();
    armed   = 1'b0;
    pend_ok = 1'b0;
    repeat (3) @(posedge c100MHz);
    #3;
    checkOutput("rst_hold_valid", res_if.valid, 0);
    checkOutput("rst_hold_period", res_if.period, 0);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    checkOutput("reset_period", res_if.period, 0);
    checkOutput("reset_high", res_if.high, 0);
    checkOutput("reset_duty", res_if.duty, 0);
    checkOutput("reset_valid", res_if.valid, 0);
    checkOutput("reset_stuck", res_if.stuck, 0);
    rst = 1'b1;
    tick(5);

    applyStimulus(4000, 2000, 2, 512);
    applyStimulus(4000, 1, 1, 0);
    applyStimulus(4000, 1000, 1, 256);
    applyStimulus(4000, 3999, 1, 1023);

    applyStimulus(10, 5, 20, 0);
    checkOutput("glitch_keep_period", res_if.period, 4000);
    checkOutput("glitch_keep_high", res_if.high, 3999);
    checkOutput("glitch_keep_duty", res_if.duty, 1023);
    checkOutput("glitch_keep_stuck", res_if.stuck, 0);
    applyStimulus(4000, 2000, 1, 512);

    holdHigh();
    checkOutput("stuck_high_level", res_if.stuck, 1);
    checkOutput("stuck_high_duty", res_if.duty, 1023);
    drivePwm(1'b0);
    tick(100);
    applyStimulus(4000, 2000, 2, 512);
    holdLow();
    checkOutput("stuck_low_level", res_if.stuck, 1);
    checkOutput("stuck_low_duty", res_if.duty, 0);

    applyStimulus(4000, 1200, 2, 307);
    applyStimulus(10000, 7500, 1, 768);
    applyStimulus(4000, 2000, 1, 512);

    resetMidDivide();
    tick(50);
    applyStimulus(4000, 2000, 2, 512);
    drivePwm(1'b1);
    tick(40);
    checkOutput("queue_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and recovers its period, high time and 10-bit duty cycle, so feeding it a signal from the team's 25 kHz motor PWM generator returns the duty word that generator was programmed with. It is used for closed-loop checks and for reading externally generated PWM such as servo/ESC lines and driver feedback. It sits on the 100 MHz fabric clock and produces one result per input period, plus a stuck-line indication.

## Interface
- CNT_W, 16: width of the period/high counters and outputs.
- TIMEOUT, 50_000: cycles without a detected rising edge before the line is declared stuck. Must satisfy 16 < TIMEOUT < 2^CNT_W.
- MIN_PERIOD, 16: periods below this are discarded as glitches.

- c100MHz  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- period  out  CNT_W  last accepted period in clocks; 0 when stuck.
- high  out  CNT_W  high time of that period in clocks; 0 when stuck.
- duty  out  10  floor(high*1024/period); 1023 when stuck high, 0 when stuck low.
- valid  out  1  one-cycle pulse when period, high and duty update.
- stuck  out  1  level; 1 while no rising edge for TIMEOUT cycles.

## Operation
- **Input sync and edge detect**
  - pwm_in passes through a 2-FF synchronizer, then a registered edge detector.
  - Rise and fall share the same fixed latency, so measurements carry no bias.
- **Free counter `cnt`**
  - Loads 1 on a rise-detect cycle.
  - Otherwise increments, saturating at TIMEOUT.
  - Its value seen on a given cycle equals the number of cycles since the last rise.
- **Capture registers**
  - On a fall-detect cycle: `hi_lat <= cnt`.
  - On a rise-detect cycle: `p_cap <= cnt`, `h_cap <= hi_lat`.
- **FSM states**
  - ARM: after reset or stuck. The first rise only loads `cnt`, no capture is taken, then go to RUN.
  - RUN: each rise takes a capture.
    - If `p_cap < MIN_PERIOD`, the capture is discarded: no output change, no valid, FSM stays in RUN.
    - Otherwise the capture starts the divider.
- **Divider**
  - Restoring, one quotient bit per cycle, 10 iterations.
  - Numerator is `h_cap` concatenated with 10 zero bits; denominator is `p_cap`.
  - Since `h_cap < p_cap`, the quotient fits in 10 bits; no saturation logic is needed.
  - A rise arriving while the divider is busy is impossible for accepted periods (MIN_PERIOD > divider latency). A discarded short capture does not disturb a divide in progress.
- **Output update** (on divider completion)
  - `period`, `high` and `duty` load together.
  - `valid` pulses.
  - `stuck` clears.
- **Timeout**
  - Condition: in RUN or ARM, `cnt` reaches TIMEOUT with no rise.
  - Actions:
    - `stuck` sets.
    - `period` and `high` go to 0.
    - `duty` goes to 1023 if the synced level is 1, else 0.
    - `valid` pulses once.
    - FSM goes to ARM and any in-flight divide is aborted.
  - Timeout fires only once per stuck episode. The saturated counter does not retrigger it.
  - `stuck` stays 1 until the next accepted result.
- **Reset**
  - Asynchronous clear at any time, including mid-divide.
  - All outputs, counters and captures go to 0; FSM to ARM; synchronizer flops to 0.

## Timing
- Pin-to-detect latency: an edge on pwm_in meeting setup before clock edge N is detected in the cycle after edge N+2.
- Capture-to-output latency: `valid` and the new outputs appear 11 cycles after the rise-detect cycle (1 load cycle + 10 iterations).
- Outputs are registered and hold between updates.
- Reset values: period=0, high=0, duty=0, valid=0, stuck=0.
- The first valid after reset follows the second detected rise, plus 11 cycles.
- Minimum measurable high or low phase is 1 cycle. Phases shorter than a clock may be missed; the bench does not drive them.

## Test plan
- 25 kHz, 50% (period 4000, high 2000), repeated → period=4000, high=2000, duty=512; valid every 4000 cycles; first valid 11 cycles after the second rise; stuck=0.
- Duty sweep at period 4000, high = 1, 1000, 3999 → duty = 0, 256, 1023 respectively, with exact `high` values.
- Period 10 cycles, 5 high, for 20 periods → no valid; outputs keep the prior values. Returning to period 4000 → valid resumes without re-arm.
- Hold pwm_in=1 after a rise → exactly TIMEOUT cycles after that rise: stuck=1, duty=1023, period=0, high=0, one valid pulse. Restart PWM → first rise gives no valid; second rise gives valid with stuck=0. Repeat the hold at 0 → duty=0.
- Frequency step from 25 kHz/30% to 10 kHz/75% (period 10000, high 7500) → the first result after the step reads period=10000, high=7500, duty=768; no intermediate mixed result.
- rst driven low for 3 cycles, asynchronously, 5 cycles after a rise capture (mid-divide) → all outputs 0 immediately, no valid. After release, the first rise only arms; valid follows the second rise.
